accumulator_writeback: RTL and testbench

- Write-back end of the calculator datapath. Consumes the overflow controller's `accept_write`/`error_flag` handshake and commits validated results into the accumulator register.
- Keeps a bounded undo history of prior accumulator values.
- Drives display-side status: value valid, error latched, blink blanking.
- Sits between the ALU/overflow-check stage and the display/operand-select logic.

---
 rtl/accumulator_writeback.sv | 125 ++++++++++++
 tb/tb_accumulator_writeback.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_writeback.sv
// Accumulator write-back stage of the calculator datapath.
// Commits validated ALU results into the accumulator, keeps a bounded undo
// history (circular LIFO that drops the oldest entry when full), and drives
// display-side status: value valid, error latched and error blink blanking.
//
// Handshake: accept_write, clear_pulse and undo_pulse are single-cycle strobes
// sampled on the rising clock edge; there is no back-pressure, every strobe
// seen high is acted on in that cycle according to the priority
// clear_pulse > accept_write > error_flag rising edge > undo_pulse.
module accumulator_writeback #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 4,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     accept_write,
   input  logic [WIDTH-1:0]         result_in,
   input  logic                     error_flag,
   input  logic                     clear_pulse,
   input  logic                     undo_pulse,
   output logic [WIDTH-1:0]         acc_out,
   output logic                     acc_valid,
   output logic                     err_latched,
   output logic                     disp_blank,
   output logic [$clog2(DEPTH):0]   hist_count,
   output logic                     undo_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0]    BLINK_TC = BW'(BLINK_DIV - 1);
   localparam logic [CNT_W-1:0] HIST_MAX = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_VALID = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t           state;
   logic             error_flag_d;
   logic [BW-1:0]    blink_cnt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] top_idx;
   logic [WIDTH-1:0] hist_mem [DEPTH];

   logic err_rise;
   logic do_push;
   logic hist_full;

   assign err_rise   = error_flag & ~error_flag_d;
   assign top_idx    = wr_ptr - PTR_W'(1);
   assign hist_full  = (hist_count == HIST_MAX);
   // Only a commit on top of an already committed value saves history.
   assign do_push    = ~clear_pulse & accept_write & acc_valid;
   assign undo_empty = (hist_count == '0);

   // History storage: write the outgoing accumulator at the write pointer.
   always_ff @(posedge clk) begin
      if (do_push) begin
         hist_mem[wr_ptr] <= acc_out;
      end
   end

   // Control FSM, accumulator, history bookkeeping and blink timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         error_flag_d <= 1'b0;
         blink_cnt    <= '0;
         wr_ptr       <= '0;
         hist_count   <= '0;
         acc_out      <= '0;
         acc_valid    <= 1'b0;
         err_latched  <= 1'b0;
         disp_blank   <= 1'b0;
      end else begin
         error_flag_d <= error_flag;
         if (clear_pulse) begin
            state       <= ST_IDLE;
            blink_cnt   <= '0;
            wr_ptr      <= '0;
            hist_count  <= '0;
            acc_out     <= '0;
            acc_valid   <= 1'b0;
            err_latched <= 1'b0;
            disp_blank  <= 1'b0;
         end else if (accept_write) begin
            // A simultaneous error edge is discarded: the commit wins.
            if (acc_valid) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               if (!hist_full) begin
                  hist_count <= hist_count + CNT_W'(1);
               end
            end
            state       <= ST_VALID;
            blink_cnt   <= '0;
            acc_out     <= result_in;
            acc_valid   <= 1'b1;
            err_latched <= 1'b0;
            disp_blank  <= 1'b0;
         end else if (err_rise && state != ST_ERROR) begin
            state       <= ST_ERROR;
            blink_cnt   <= '0;
            err_latched <= 1'b1;
            disp_blank  <= 1'b0;
         end else if (state == ST_ERROR) begin
            // Accumulator frozen; only the blink timer advances.
            if (blink_cnt == BLINK_TC) begin
               blink_cnt  <= '0;
               disp_blank <= ~disp_blank;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end else if (undo_pulse && state == ST_VALID && hist_count != '0) begin
            acc_out    <= hist_mem[top_idx];
            wr_ptr     <= top_idx;
            hist_count <= hist_count - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_accumulator_writeback.sv
// Bench for accumulator_writeback with DEPTH=4, BLINK_DIV=4.
module tb_accumulator_writeback;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int BD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          accept_write = 1'b0;
   logic [W-1:0]  result_in = '0;
   logic          error_flag = 1'b0;
   logic          clear_pulse = 1'b0;
   logic          undo_pulse = 1'b0;
   logic [W-1:0]  acc_out;
   logic          acc_valid;
   logic          err_latched;
   logic          disp_blank;
   logic [$clog2(D):0] hist_count;
   logic          undo_empty;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [W-1:0] m_acc;
   logic         m_valid;
   logic         m_err;
   int           m_ecyc;
   logic         m_prev_ef;
   logic [W-1:0] m_hist[$];

   accumulator_writeback #(.WIDTH(W), .DEPTH(D), .BLINK_DIV(BD)) dut (
      .clk(clk), .rst(rst), .accept_write(accept_write), .result_in(result_in),
      .error_flag(error_flag), .clear_pulse(clear_pulse), .undo_pulse(undo_pulse),
      .acc_out(acc_out), .acc_valid(acc_valid), .err_latched(err_latched),
      .disp_blank(disp_blank), .hist_count(hist_count), .undo_empty(undo_empty)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_acc = '0; m_valid = 1'b0; m_err = 1'b0; m_ecyc = 0; m_prev_ef = 1'b0;
      m_hist.delete();
   endtask

   function automatic logic exp_blank();
      return m_err && (((m_ecyc / BD) % 2) == 1);
   endfunction

   task automatic model_update(input logic aw, input logic [W-1:0] res, input logic ef,
                               input logic clr, input logic und);
      logic rise;
      rise = ef & ~m_prev_ef;
      m_prev_ef = ef;
      if (clr) begin
         m_acc = '0; m_valid = 1'b0; m_err = 1'b0; m_ecyc = 0; m_hist.delete();
      end else if (aw) begin
         if (m_valid) begin
            m_hist.push_back(m_acc);
            if (m_hist.size() > D) void'(m_hist.pop_front());
         end
         m_acc = res; m_valid = 1'b1; m_err = 1'b0; m_ecyc = 0;
      end else if (rise && !m_err) begin
         m_err = 1'b1; m_ecyc = 0;
      end else if (m_err) begin
         m_ecyc++;
      end else if (und && m_valid && m_hist.size() > 0) begin
         m_acc = m_hist.pop_back();
      end
   endtask

   // drive one cycle of inputs, clock it, update the model, settle 1 time unit
   task automatic step(input logic aw, input logic [W-1:0] res, input logic ef,
                       input logic clr, input logic und);
      accept_write = aw; result_in = res; error_flag = ef;
      clear_pulse = clr; undo_pulse = und;
      @(posedge clk);
      model_update(aw, res, ef, clr, und);
      #1;
      accept_write = 1'b0; clear_pulse = 1'b0; undo_pulse = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      total++; if (acc_out !== 16'h0) begin bad++; $display("FAIL reset_acc got=%h want=0", acc_out); end
      total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", acc_valid); end
      total++; if (err_latched !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_latched); end
      total++; if (disp_blank !== 1'b0) begin bad++; $display("FAIL reset_blank got=%b want=0", disp_blank); end
      total++; if (hist_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", hist_count); end
      total++; if (undo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", undo_empty); end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_first_write();
      step(1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
      total++; if (acc_out !== 16'h0012) begin bad++; $display("FAIL first_acc got=%h want=0012", acc_out); end
      total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", acc_valid); end
      total++; if (hist_count !== 3'd0) begin bad++; $display("FAIL first_count got=%0d want=0", hist_count); end
      total++; if (undo_empty !== 1'b1) begin bad++; $display("FAIL first_empty got=%b want=1", undo_empty); end
   endtask

   task automatic test_history();
      logic [W-1:0] want;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
      total++; if (acc_out !== 16'd6) begin bad++; $display("FAIL hist_acc6 got=%0d want=6", acc_out); end
      total++; if (hist_count !== 3'd4) begin bad++; $display("FAIL hist_full got=%0d want=4", hist_count); end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b0, 1'b0, 1'b1);
         want = W'(5 - i);
         total++; if (acc_out !== want) begin bad++; $display("FAIL undo_%0d got=%0d want=%0d", i, acc_out, want); end
         total++; if (hist_count !== 3'(3 - i)) begin bad++; $display("FAIL undo_cnt_%0d got=%0d want=%0d", i, hist_count, 3 - i); end
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      total++; if (acc_out !== 16'd2) begin bad++; $display("FAIL undo_extra got=%0d want=2", acc_out); end
      total++; if (undo_empty !== 1'b1) begin bad++; $display("FAIL undo_extra_empty got=%b want=1", undo_empty); end
   endtask

   task automatic test_error_blink();
      logic want_b;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 16'd7, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      total++; if (err_latched !== 1'b1) begin bad++; $display("FAIL err_enter got=%b want=1", err_latched); end
      total++; if (acc_out !== 16'd7) begin bad++; $display("FAIL err_acc got=%0d want=7", acc_out); end
      for (int k = 1; k <= 12; k++) begin
         step(1'b0, '0, 1'b1, 1'b0, k[0]);
         want_b = ((k / 4) % 2) == 1;
         total++; if (disp_blank !== want_b) begin bad++; $display("FAIL blink_k%0d got=%b want=%b", k, disp_blank, want_b); end
         total++; if (acc_out !== 16'd7) begin bad++; $display("FAIL err_frozen_k%0d got=%0d want=7", k, acc_out); end
      end
      step(1'b1, 16'd9, 1'b1, 1'b0, 1'b0);
      total++; if (acc_out !== 16'd9) begin bad++; $display("FAIL err_exit_acc got=%0d want=9", acc_out); end
      total++; if (err_latched !== 1'b0) begin bad++; $display("FAIL err_exit_err got=%b want=0", err_latched); end
      total++; if (disp_blank !== 1'b0) begin bad++; $display("FAIL err_exit_blank got=%b want=0", disp_blank); end
      total++; if (hist_count !== 3'd1) begin bad++; $display("FAIL err_exit_count got=%0d want=1", hist_count); end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      total++; if (err_latched !== 1'b0) begin bad++; $display("FAIL err_no_reenter got=%b want=0", err_latched); end
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      total++; if (acc_out !== 16'd7) begin bad++; $display("FAIL undo_after_err got=%0d want=7", acc_out); end
   endtask

   task automatic test_clear_in_error();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      total++; if (err_latched !== 1'b1) begin bad++; $display("FAIL clr_err_enter got=%b want=1", err_latched); end
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      total++; if (acc_out !== 16'h0) begin bad++; $display("FAIL clr_acc got=%h want=0", acc_out); end
      total++; if ({acc_valid, err_latched, disp_blank} !== 3'b000) begin bad++; $display("FAIL clr_flags got=%b want=000", {acc_valid, err_latched, disp_blank}); end
      total++; if (hist_count !== 3'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", hist_count); end
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      total++; if (err_latched !== 1'b0) begin bad++; $display("FAIL clr_no_reenter got=%b want=0", err_latched); end
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      total++; if (err_latched !== 1'b1) begin bad++; $display("FAIL clr_reenter got=%b want=1", err_latched); end
   endtask

   task automatic test_clear_vs_write();
      step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h00AA, 1'b0, 1'b1, 1'b0);
      total++; if (acc_out !== 16'h0) begin bad++; $display("FAIL clr_wins_acc got=%h want=0", acc_out); end
      total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL clr_wins_valid got=%b want=0", acc_valid); end
   endtask

   task automatic test_async_reset();
      step(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      total++; if (disp_blank !== 1'b1) begin bad++; $display("FAIL pre_rst_blank got=%b want=1", disp_blank); end
      #2 rst = 1'b1;
      #1;
      total++; if (acc_out !== 16'h0) begin bad++; $display("FAIL arst_acc got=%h want=0", acc_out); end
      total++; if ({acc_valid, err_latched, disp_blank} !== 3'b000) begin bad++; $display("FAIL arst_flags got=%b want=000", {acc_valid, err_latched, disp_blank}); end
      total++; if (undo_empty !== 1'b1) begin bad++; $display("FAIL arst_empty got=%b want=1", undo_empty); end
      error_flag = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      logic ef;
      ef = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 4) == 0) ef = ~ef;
         step($urandom_range(0, 3) == 0, W'($urandom), ef,
              $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
         total++;
         if (acc_out !== m_acc || acc_valid !== m_valid || err_latched !== m_err ||
             disp_blank !== exp_blank() || hist_count !== 3'(m_hist.size()) ||
             undo_empty !== (m_hist.size() == 0)) begin
            bad++;
            $display("FAIL rand_%0d got acc=%h v=%b e=%b b=%b c=%0d u=%b want acc=%h v=%b e=%b b=%b c=%0d",
                     n, acc_out, acc_valid, err_latched, disp_blank, hist_count, undo_empty,
                     m_acc, m_valid, m_err, exp_blank(), m_hist.size());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_first_write();
      test_history();
      test_error_blink();
      test_clear_in_error();
      test_clear_vs_write();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
